// File: rtl/tdm_spike_encoder.sv
// -----------------------------------------------------------------------------
// tdm_spike_encoder
//
// Watches the per-slot writeback stream of the TDM neuron core and turns
// upward threshold crossings into timestamped spike events. Each neuron keeps
// one "above threshold" bit. A spike fires only on the slot where that bit goes
// from 0 to 1. Events are queued in a small circular FIFO and leave on a
// valid/ready stream.
//
// Ports
//   clk         clock
//   rst         synchronous reset, active low
//   enable      event generation enable (state bits track regardless)
//   threshold   signed Q4.12 spike threshold
//   wb_valid    writeback slot valid
//   wb_id       neuron id of the slot
//   wb_v        signed Q4.12 updated membrane value
//   ev_valid    event available at the FIFO head
//   ev_ready    consumer accepts the head event
//   ev_data     {timestamp, neuron id}, id in the LSBs
//   fifo_level  current FIFO occupancy
//   overflow    sticky, set when an event was dropped on a full FIFO
//   drop_count  saturating count of dropped events
//   clear_ovf   clears overflow and drop_count
// -----------------------------------------------------------------------------
module tdm_spike_encoder #(
  parameter int NEURON_COUNT = 500,
  parameter int DATA_WIDTH   = 16,
  parameter int TS_WIDTH     = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int ID_W         = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_WIDTH-1:0]         threshold,
  input  logic                          wb_valid,
  input  logic [ID_W-1:0]               wb_id,
  input  logic [DATA_WIDTH-1:0]         wb_v,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [TS_WIDTH+ID_W-1:0]      ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  input  logic                          clear_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int EV_W  = TS_WIDTH + ID_W;

  // Id range check is done one bit wider so NEURON_COUNT itself is representable.
  localparam logic [ID_W:0]      ID_LIMIT = (ID_W + 1)'(NEURON_COUNT);
  localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(NEURON_COUNT - 1);
  localparam logic [LVL_W-1:0]   FULL_LVL = LVL_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Crossing detection
  // ---------------------------------------------------------------------------
  logic [NEURON_COUNT-1:0] above_q, above_d;
  logic                    slot_taken;
  logic                    above;
  logic                    was_above;
  logic                    spike;

  assign slot_taken = wb_valid && ({1'b0, wb_id} < ID_LIMIT);
  assign above      = $signed(wb_v) >= $signed(threshold);
  assign was_above  = above_q[wb_id];
  assign spike      = slot_taken && above && !was_above && enable;

  // The state bit follows the comparison on every taken slot, even when
  // disabled, so raising enable never fires on a neuron already above.
  always_comb begin
    above_d = above_q;
    if (slot_taken) begin
      above_d[wb_id] = above;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter: advances after the last neuron of the frame; the event for
  // that slot still carries the pre-increment frame number.
  // ---------------------------------------------------------------------------
  logic [TS_WIDTH-1:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (slot_taken && (wb_id == LAST_ID)) begin
      frame_d = frame_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [EV_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [EV_W-1:0]  ev_word;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);
  assign pop        = !fifo_empty && ev_ready;
  // A full FIFO still accepts the new event when the head leaves this cycle.
  assign push       = spike && (!fifo_full || pop);
  assign drop       = spike && fifo_full && !pop;
  assign ev_word    = {frame_q, wb_id};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Overflow tracking: a drop in the same cycle as clear_ovf wins.
  // ---------------------------------------------------------------------------
  logic        ovf_q, ovf_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_d != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_d + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      above_q    <= '0;
      frame_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      above_q    <= above_d;
      frame_q    <= frame_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ev_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. ev_data is forced to zero while empty so stale entries never show.
  // ---------------------------------------------------------------------------
  assign ev_valid   = !fifo_empty;
  assign ev_data    = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_tdm_spike_encoder.sv
// Testbench for tdm_spike_encoder: directed scenarios plus a randomized phase,
// all checked against a queue-based reference model.
module tb_tdm_spike_encoder;

  localparam int N     = 5;
  localparam int DW    = 16;
  localparam int TSW   = 4;
  localparam int DEPTH = 4;
  localparam int IDW   = 3;
  localparam int EW    = TSW + IDW;
  localparam int LW    = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [DW-1:0]  threshold;
  logic           wb_valid;
  logic [IDW-1:0] wb_id;
  logic [DW-1:0]  wb_v;
  logic           ev_valid;
  logic           ev_ready;
  logic [EW-1:0]  ev_data;
  logic [LW-1:0]  fifo_level;
  logic           overflow;
  logic [15:0]    drop_count;
  logic           clear_ovf;

  tdm_spike_encoder #(
    .NEURON_COUNT(N),
    .DATA_WIDTH  (DW),
    .TS_WIDTH    (TSW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .threshold (threshold),
    .wb_valid  (wb_valid),
    .wb_id     (wb_id),
    .wb_v      (wb_v),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_data   (ev_data),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .drop_count(drop_count),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-neuron above bits, a frame number, an event queue.
  bit            m_st [N];
  int            m_frame;
  logic [EW-1:0] m_q [$];
  bit            m_ovf;
  int            m_dc;

  task automatic model_update();
    bit            pop, taken, above, spike, drop;
    logic [EW-1:0] ev;
    int            id;
    if (!rst) begin
      m_q.delete();
      m_frame = 0;
      m_ovf   = 0;
      m_dc    = 0;
      foreach (m_st[i]) m_st[i] = 0;
      return;
    end
    id    = int'(wb_id);
    pop   = (m_q.size() != 0) && ev_ready;
    taken = wb_valid && (id < N);
    above = $signed(wb_v) >= $signed(threshold);
    spike = 0;
    ev    = {m_frame[TSW-1:0], wb_id};
    if (taken) begin
      spike    = above && !m_st[id] && enable;
      m_st[id] = above;
      if (id == N - 1) m_frame = (m_frame + 1) % (1 << TSW);
    end
    drop = spike && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (spike && !drop) m_q.push_back(ev);
    if (clear_ovf) begin
      m_ovf = 0;
      m_dc  = 0;
    end
    if (drop) begin
      m_ovf = 1;
      if (m_dc < 65535) m_dc++;
    end
  endtask

  task automatic compare_all();
    check_eq("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
    check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    if (m_q.size() != 0) check_eq("ev_data", 32'(ev_data), 32'(m_q[0]));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("drop_count", 32'(drop_count), 32'(m_dc));
  endtask

  // Inputs are set away from the edge; outputs are sampled 1 time unit after it.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic slot(input int id, input int v);
    wb_valid = 1'b1;
    wb_id    = id[IDW-1:0];
    wb_v     = v[DW-1:0];
    step();
    wb_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame(input int hot_id, input int hot_v);
    for (int i = 0; i < N; i++) slot(i, (i == hot_id) ? hot_v : 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  logic [EW-1:0] exp_ev;

  initial begin
    rst       = 1'b0;
    enable    = 1'b1;
    threshold = 16'd4096;
    wb_valid  = 1'b0;
    wb_id     = '0;
    wb_v      = '0;
    ev_ready  = 1'b0;
    clear_ovf = 1'b0;
    #2;
    do_reset();
    check_eq("rst_valid", 32'(ev_valid), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_data", 32'(ev_data), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_drops", 32'(drop_count), 32'd0);

    // 1: single crossing and re-arming
    frame(-1, 0);
    slot(0, 0); slot(1, 0); slot(2, 4096);
    check_eq("t1_valid", 32'(ev_valid), 32'd1);
    check_eq("t1_data", 32'(ev_data), 32'({4'd1, 3'd2}));
    slot(3, 0); slot(4, 0);
    frame(2, 5000);
    check_eq("t1_still_above", 32'(fifo_level), 32'd1);
    frame(2, 100);
    slot(0, 0); slot(1, 0); slot(2, 4096);
    check_eq("t1_rearm_level", 32'(fifo_level), 32'd2);
    slot(3, 0); slot(4, 0);
    ev_ready = 1'b1;
    idle(1);
    check_eq("t1_second_ts", 32'(ev_data), 32'({4'd4, 3'd2}));
    idle(1);
    check_eq("t1_drained", 32'(fifo_level), 32'd0);
    ev_ready = 1'b0;

    // 2: negative threshold boundary, out-of-range id
    do_reset();
    threshold = 16'hF800;  // -2048
    slot(0, -2049);
    check_eq("t2_below", 32'(fifo_level), 32'd0);
    slot(0, -2048);
    check_eq("t2_equal", 32'(fifo_level), 32'd1);
    check_eq("t2_data", 32'(ev_data), 32'({4'd0, 3'd0}));
    slot(5, 1000);
    check_eq("t2_oor_id", 32'(fifo_level), 32'd1);
    slot(4, -3000);
    slot(1, 0);
    check_eq("t2_after_oor", 32'(fifo_level), 32'd2);

    // 3: overflow, clear, drop beating clear
    do_reset();
    threshold = 16'd4096;
    for (int i = 0; i < N; i++) slot(i, 4096);
    slot(0, 0); slot(0, 5000);
    check_eq("t3_level", 32'(fifo_level), 32'd4);
    check_eq("t3_ovf", 32'(overflow), 32'd1);
    check_eq("t3_drops", 32'(drop_count), 32'd2);
    check_eq("t3_head", 32'(ev_data), 32'({4'd0, 3'd0}));
    clear_ovf = 1'b1;
    idle(1);
    clear_ovf = 1'b0;
    check_eq("t3_clr_ovf", 32'(overflow), 32'd0);
    check_eq("t3_clr_drops", 32'(drop_count), 32'd0);
    check_eq("t3_clr_level", 32'(fifo_level), 32'd4);
    slot(2, 0);
    clear_ovf = 1'b1;
    slot(2, 4096);
    clear_ovf = 1'b0;
    check_eq("t3_drop_wins_ovf", 32'(overflow), 32'd1);
    check_eq("t3_drop_wins_cnt", 32'(drop_count), 32'd1);

    // 4: full with simultaneous pop
    slot(1, 0);
    ev_ready = 1'b1;
    slot(1, 4096);
    check_eq("t4_level", 32'(fifo_level), 32'd4);
    check_eq("t4_no_drop", 32'(drop_count), 32'd1);
    idle(3);
    check_eq("t4_last", 32'(ev_data), 32'({4'd1, 3'd1}));
    idle(1);
    check_eq("t4_empty", 32'(fifo_level), 32'd0);
    ev_ready = 1'b0;

    // 5: enable gating
    do_reset();
    enable = 1'b0;
    slot(1, 4096);
    check_eq("t5_disabled", 32'(fifo_level), 32'd0);
    enable = 1'b1;
    slot(1, 4096);
    check_eq("t5_still_above", 32'(fifo_level), 32'd0);
    slot(1, 0);
    slot(1, 4096);
    check_eq("t5_recross", 32'(ev_data), 32'({4'd0, 3'd1}));

    // 6: timestamp wrap, reset mid-stream
    do_reset();
    ev_ready = 1'b1;
    for (int f = 0; f < 17; f++) begin
      slot(0, 0);
      slot(0, 4096);
      exp_ev = {4'(f % 16), 3'd0};
      check_eq("t6_ts", 32'(ev_data), 32'(exp_ev));
      for (int i = 1; i < N; i++) slot(i, 0);
    end
    ev_ready = 1'b0;
    slot(1, 4096); slot(2, 4096); slot(3, 4096);
    check_eq("t6_queued", 32'(fifo_level), 32'd3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_eq("t6_rst_valid", 32'(ev_valid), 32'd0);
    check_eq("t6_rst_level", 32'(fifo_level), 32'd0);
    slot(2, 4096);
    check_eq("t6_post_valid", 32'(ev_valid), 32'd1);
    check_eq("t6_post_data", 32'(ev_data), 32'({4'd0, 3'd2}));

    // Randomized phase
    do_reset();
    threshold = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      int t;
      int v;
      t = int'($signed(threshold));
      if ($urandom_range(0, 1) == 0) v = t + int'($urandom_range(0, 8)) - 4;
      else v = int'($urandom_range(0, 65535));
      wb_valid  = ($urandom_range(0, 3) != 0);
      wb_id     = 3'($urandom_range(0, 7));
      wb_v      = v[DW-1:0];
      enable    = ($urandom_range(0, 9) != 0);
      ev_ready  = ($urandom_range(0, 2) == 0);
      clear_ovf = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 499) != 0);
      step();
    end
    wb_valid  = 1'b0;
    clear_ovf = 1'b0;
    rst       = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
